// File: rtl/trap_csr_unit_if.sv
// rtl/trap_csr_unit_if.sv - trap packet types and the trap/CSR port interface of trap_csr_unit
package trap_csr_unit_pkg;
  typedef enum logic [1:0] {
    TRAP_NONE   = 2'd0,
    TRAP_ENTER  = 2'd1,
    TRAP_RETURN = 2'd2
  } trap_mode_e;

  typedef struct packed {
    logic        valid;
    trap_mode_e  mode;
    logic [4:0]  cause;
    logic [31:0] pc;
    logic [31:0] tval;
  } trap_pkt_t;
endpackage

interface trap_csr_unit_if;
  import trap_csr_unit_pkg::*;

  trap_pkt_t   trap_pkt;
  logic        retire;
  logic [11:0] csr_addr;
  logic [1:0]  csr_op;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mie_out;

  modport master (
    output trap_pkt, retire, csr_addr, csr_op, csr_wdata,
    input  csr_rdata, csr_illegal, redirect_valid, redirect_pc, mie_out
  );

  modport slave (
    input  trap_pkt, retire, csr_addr, csr_op, csr_wdata,
    output csr_rdata, csr_illegal, redirect_valid, redirect_pc, mie_out
  );
endinterface

// File: rtl/trap_csr_unit.sv
// rtl/trap_csr_unit.sv - M-mode trap state, CSR read/modify/write port and PC redirect
// Optional mcycle/minstret counters are built when TRAP_CSR_COUNTERS_EN is defined.
module trap_csr_unit
  import trap_csr_unit_pkg::*;
#(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0000,
  parameter logic [31:0] MHARTID     = 32'h0000_0000
) (
  input logic           clk,
  input logic           reset,
  trap_csr_unit_if.slave bus
);
  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MTVAL    = 12'h343;
  localparam logic [11:0] ADDR_MHARTID  = 12'hF14;
  localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET = 12'hB80;
  localparam logic [11:0] ADDR_MCYCLEH  = 12'hB02;
  localparam logic [11:0] ADDR_MINSTRETH= 12'hB82;

  localparam logic [1:0] OP_NONE  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_SET   = 2'b10;

  logic        mie, mpie;
  logic [31:0] mepc, mcause, mtval, mtvec, mscratch;
  logic [31:0] rdata, wval;
  logic        implemented, read_only, illegal, wr_en;
  logic        trap_valid, trap_enter, trap_return;

`ifdef TRAP_CSR_COUNTERS_EN
  logic [63:0] mcycle, minstret;
`endif

  assign trap_valid  = bus.trap_pkt.valid;
  assign trap_enter  = trap_valid && (bus.trap_pkt.mode == TRAP_ENTER);
  assign trap_return = trap_valid && (bus.trap_pkt.mode == TRAP_RETURN);

  always_comb begin
    rdata       = 32'h0;
    implemented = 1'b1;
    read_only   = 1'b0;
    case (bus.csr_addr)
      ADDR_MSTATUS:  rdata = {19'h0, 2'b11, 3'h0, mpie, 3'h0, mie, 3'h0};
      ADDR_MTVEC:    rdata = mtvec;
      ADDR_MSCRATCH: rdata = mscratch;
      ADDR_MEPC:     rdata = mepc;
      ADDR_MCAUSE:   rdata = mcause;
      ADDR_MTVAL:    rdata = mtval;
      ADDR_MHARTID: begin
        rdata     = MHARTID;
        read_only = 1'b1;
      end
`ifdef TRAP_CSR_COUNTERS_EN
      ADDR_MCYCLE:    rdata = mcycle[31:0];
      ADDR_MCYCLEH:   rdata = mcycle[63:32];
      ADDR_MINSTRET:  rdata = minstret[31:0];
      ADDR_MINSTRETH: rdata = minstret[63:32];
`endif
      default: implemented = 1'b0;
    endcase
  end

  // set/clear with zero data is a pure read, so it stays legal on read-only CSRs
  assign illegal = (bus.csr_op != OP_NONE) &&
                   (!implemented ||
                    (read_only && (bus.csr_op == OP_WRITE || bus.csr_wdata != 32'h0)));

  always_comb begin
    case (bus.csr_op)
      OP_WRITE: wval = bus.csr_wdata;
      OP_SET:   wval = rdata | bus.csr_wdata;
      default:  wval = rdata & ~bus.csr_wdata;
    endcase
  end

  assign wr_en = (bus.csr_op != OP_NONE) && !illegal && !trap_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      mie      <= 1'b0;
      mpie     <= 1'b0;
      mepc     <= 32'h0;
      mcause   <= 32'h0;
      mtval    <= 32'h0;
      mscratch <= 32'h0;
      mtvec    <= {RESET_MTVEC[31:2], 2'b00};
    end else if (trap_enter) begin
      mepc   <= {bus.trap_pkt.pc[31:2], 2'b00};
      mcause <= {27'h0, bus.trap_pkt.cause};
      mtval  <= bus.trap_pkt.tval;
      mpie   <= mie;
      mie    <= 1'b0;
    end else if (trap_return) begin
      mie  <= mpie;
      mpie <= 1'b1;
    end else if (wr_en) begin
      case (bus.csr_addr)
        ADDR_MSTATUS: begin
          mie  <= wval[3];
          mpie <= wval[7];
        end
        ADDR_MTVEC:    mtvec    <= {wval[31:2], 2'b00};
        ADDR_MSCRATCH: mscratch <= wval;
        ADDR_MEPC:     mepc     <= {wval[31:2], 2'b00};
        ADDR_MCAUSE:   mcause   <= wval;
        ADDR_MTVAL:    mtval    <= wval;
        default: ;
      endcase
    end
  end

`ifdef TRAP_CSR_COUNTERS_EN
  // a software write to either half wins over that cycle's increment
  always_ff @(posedge clk) begin
    if (reset) begin
      mcycle   <= 64'h0;
      minstret <= 64'h0;
    end else begin
      if (wr_en && bus.csr_addr == ADDR_MCYCLE)       mcycle[31:0]  <= wval;
      else if (wr_en && bus.csr_addr == ADDR_MCYCLEH) mcycle[63:32] <= wval;
      else                                            mcycle        <= mcycle + 64'd1;

      if (wr_en && bus.csr_addr == ADDR_MINSTRET)       minstret[31:0]  <= wval;
      else if (wr_en && bus.csr_addr == ADDR_MINSTRETH) minstret[63:32] <= wval;
      else if (bus.retire && !trap_valid)               minstret        <= minstret + 64'd1;
    end
  end
`else
  logic unused_retire;
  assign unused_retire = bus.retire;
`endif

  logic unused_pc_bits;
  assign unused_pc_bits = ^bus.trap_pkt.pc[1:0];

  assign bus.csr_rdata      = implemented ? rdata : 32'h0;
  assign bus.csr_illegal    = illegal;
  assign bus.redirect_valid = trap_valid && (bus.trap_pkt.mode != TRAP_NONE);
  assign bus.redirect_pc    = trap_enter  ? mtvec :
                              trap_return ? mepc  : 32'h0;
  assign bus.mie_out        = mie;
endmodule

// File: tb/tb_trap_csr_unit.sv
// tb/tb_trap_csr_unit.sv - directed self-checking bench for trap_csr_unit
module tb_trap_csr_unit;
  import trap_csr_unit_pkg::*;

  localparam logic [31:0] P_MTVEC   = 32'h1000_0007;
  localparam logic [31:0] P_MHARTID = 32'h0000_002A;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  trap_csr_unit_if bus();

  trap_csr_unit #(.RESET_MTVEC(P_MTVEC), .MHARTID(P_MHARTID)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.trap_pkt  = '0;
    bus.retire    = 1'b0;
    bus.csr_addr  = 12'h0;
    bus.csr_op    = 2'b00;
    bus.csr_wdata = 32'h0;
  endtask

  task automatic set_csr(input logic [11:0] addr, input logic [1:0] op, input logic [31:0] data);
    bus.csr_addr  = addr;
    bus.csr_op    = op;
    bus.csr_wdata = data;
  endtask

  task automatic set_trap(input trap_mode_e mode, input logic [4:0] cause,
                          input logic [31:0] pc, input logic [31:0] tval);
    bus.trap_pkt.valid = 1'b1;
    bus.trap_pkt.mode  = mode;
    bus.trap_pkt.cause = cause;
    bus.trap_pkt.pc    = pc;
    bus.trap_pkt.tval  = tval;
  endtask

  task automatic rd(input logic [11:0] addr, input logic [31:0] exp, input string tag);
    @(negedge clk);
    set_csr(addr, 2'b00, 32'h0);
    #1 chk(tag, bus.csr_rdata, exp);
  endtask

  task automatic wr(input logic [11:0] addr, input logic [1:0] op, input logic [31:0] data);
    @(negedge clk);
    set_csr(addr, op, data);
    @(posedge clk);
    #1 idle();
  endtask

  task automatic commit();
    @(posedge clk);
    #1 idle();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;

    rd(12'h300, 32'h0000_1800, "reset_mstatus");
    chk("reset_illegal", {31'h0, bus.csr_illegal}, 32'h0);
    chk("reset_mie_out", {31'h0, bus.mie_out}, 32'h0);
    rd(12'h305, 32'h1000_0004, "reset_mtvec");
    rd(12'h341, 32'h0, "reset_mepc");

    @(negedge clk);
    set_csr(12'h305, 2'b01, 32'h8000_0103);
    #1 chk("mtvec_wr_illegal", {31'h0, bus.csr_illegal}, 32'h0);
    commit();
    rd(12'h305, 32'h8000_0100, "mtvec_masked");
    wr(12'h300, 2'b10, 32'h0000_0008);
    rd(12'h300, 32'h0000_1808, "mstatus_set_mie");
    chk("mie_out_set", {31'h0, bus.mie_out}, 32'h1);

    // trap entry with a coincident mstatus clear that must be dropped
    @(negedge clk);
    set_trap(TRAP_ENTER, 5'd2, 32'h0000_0040, 32'hFFFF_FFFF);
    set_csr(12'h300, 2'b11, 32'h0000_0008);
    #1;
    chk("enter_redirect_valid", {31'h0, bus.redirect_valid}, 32'h1);
    chk("enter_redirect_pc", bus.redirect_pc, 32'h8000_0100);
    chk("enter_rdata_old", bus.csr_rdata, 32'h0000_1808);
    commit();
    rd(12'h341, 32'h0000_0040, "enter_mepc");
    rd(12'h342, 32'h0000_0002, "enter_mcause");
    rd(12'h343, 32'hFFFF_FFFF, "enter_mtval");
    rd(12'h300, 32'h0000_1880, "enter_mstatus");
    chk("enter_mie_out", {31'h0, bus.mie_out}, 32'h0);

    // return with a coincident mstatus write of zero that must be dropped
    @(negedge clk);
    set_trap(TRAP_RETURN, 5'd0, 32'h0, 32'h0);
    set_csr(12'h300, 2'b01, 32'h0);
    #1 chk("return_redirect_pc", bus.redirect_pc, 32'h0000_0040);
    commit();
    rd(12'h300, 32'h0000_1888, "return_mstatus");
    chk("return_mie_out", {31'h0, bus.mie_out}, 32'h1);
    rd(12'h341, 32'h0000_0040, "return_mepc_kept");

    @(negedge clk);
    set_trap(TRAP_ENTER, 5'd3, 32'h0000_0103, 32'h5);
    commit();
    rd(12'h300, 32'h0000_1880, "nest1_mstatus");
    rd(12'h341, 32'h0000_0100, "nest1_mepc_aligned");
    @(negedge clk);
    set_trap(TRAP_ENTER, 5'd7, 32'h0000_0200, 32'h9);
    commit();
    rd(12'h300, 32'h0000_1800, "nest2_mstatus");
    rd(12'h341, 32'h0000_0200, "nest2_mepc");
    rd(12'h342, 32'h0000_0007, "nest2_mcause");
    rd(12'h343, 32'h0000_0009, "nest2_mtval");

    @(negedge clk);
    set_trap(TRAP_NONE, 5'd0, 32'h44, 32'h0);
    #1;
    chk("none_redirect_valid", {31'h0, bus.redirect_valid}, 32'h0);
    chk("none_redirect_pc", bus.redirect_pc, 32'h0);
    idle();

    wr(12'h341, 2'b01, 32'h1234_5677);
    rd(12'h341, 32'h1234_5674, "mepc_masked");
    wr(12'h340, 2'b01, 32'hA5A5_A5A5);
    wr(12'h340, 2'b11, 32'h0F0F_0F0F);
    rd(12'h340, 32'hA0A0_A0A0, "mscratch_clear");
    wr(12'h342, 2'b01, 32'h8000_000B);
    rd(12'h342, 32'h8000_000B, "mcause_full");

    @(negedge clk);
    set_csr(12'h7C0, 2'b01, 32'hDEAD_BEEF);
    #1;
    chk("unimpl_illegal", {31'h0, bus.csr_illegal}, 32'h1);
    chk("unimpl_rdata", bus.csr_rdata, 32'h0);
    set_csr(12'h7C0, 2'b00, 32'h0);
    #1 chk("unimpl_noop_legal", {31'h0, bus.csr_illegal}, 32'h0);
    set_csr(12'hF14, 2'b01, 32'h0);
    #1 chk("mhartid_write_illegal", {31'h0, bus.csr_illegal}, 32'h1);
    set_csr(12'hF14, 2'b10, 32'h0);
    #1;
    chk("mhartid_rs0_legal", {31'h0, bus.csr_illegal}, 32'h0);
    chk("mhartid_rdata", bus.csr_rdata, P_MHARTID);
    set_csr(12'hF14, 2'b11, 32'h1);
    #1 chk("mhartid_clear_illegal", {31'h0, bus.csr_illegal}, 32'h1);
    commit();
    rd(12'h340, 32'hA0A0_A0A0, "unimpl_no_side_effect");

`ifdef TRAP_CSR_COUNTERS_EN
    wr(12'hB02, 2'b01, 32'h0000_0007);
    wr(12'hB00, 2'b01, 32'hFFFF_FFFF);
    @(posedge clk);
    rd(12'hB00, 32'h0, "mcycle_low_wrap");
    rd(12'hB02, 32'h0000_0008, "mcycle_high_carry");

    wr(12'hB80, 2'b01, 32'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.retire = 1'b1;
      if (i == 2) set_trap(TRAP_NONE, 5'd0, 32'h0, 32'h0);
      commit();
    end
    rd(12'hB80, 32'h0000_0004, "minstret_count");
    rd(12'hB82, 32'h0, "minstret_high");

    @(negedge clk);
    reset = 1'b1;
    set_csr(12'hB00, 2'b00, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    #1 chk("ctr_reset_mcycle", bus.csr_rdata, 32'h0);
    set_csr(12'hB02, 2'b00, 32'h0);
    #1 chk("ctr_reset_mcycleh", bus.csr_rdata, 32'h0);
    set_csr(12'hB80, 2'b00, 32'h0);
    #1 chk("ctr_reset_minstret", bus.csr_rdata, 32'h0);
`else
    @(negedge clk);
    set_csr(12'hB00, 2'b10, 32'h0);
    #1;
    chk("nocnt_mcycle_illegal", {31'h0, bus.csr_illegal}, 32'h1);
    chk("nocnt_mcycle_rdata", bus.csr_rdata, 32'h0);
    idle();
`endif

    // reset wins over a trap entry and a CSR write in the same cycle
    @(negedge clk);
    reset = 1'b1;
    set_trap(TRAP_ENTER, 5'd4, 32'h0000_0300, 32'h1);
    set_csr(12'h340, 2'b01, 32'h0000_FFFF);
    @(posedge clk);
    #1 idle();
    @(negedge clk) reset = 1'b0;
    rd(12'h340, 32'h0, "rst_override_mscratch");
    rd(12'h341, 32'h0, "rst_override_mepc");
    rd(12'h305, 32'h1000_0004, "rst_override_mtvec");
    rd(12'h300, 32'h0000_1800, "rst_override_mstatus");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/trap_csr_unit.md
Name: trap_csr_unit

Overview:
- Machine-mode trap consumer: accepts `trap_pkt_t` from the trap packet generator and commits trap state into the M-mode CSRs.
- CSRs held: `mstatus`, `mepc`, `mcause`, `mtval`, `mtvec`, `mscratch`.
- Produces the PC redirect for trap entry and `mret`.
- Serves the Zicsr read/modify/write port of the single-cycle core.

Parameters:
- RESET_MTVEC, 32'h0000_0000, reset value of `mtvec` (bits [1:0] forced to 0).
- MHARTID, 32'h0000_0000, value returned for `mhartid` (0xF14).

Ports:
- clk  input  1  core clock
- reset  input  1  synchronous, active-high reset
- trap_pkt  input  trap_pkt_t  `{valid, mode, cause, pc, tval}` from the trap packet generator
- retire  input  1  one instruction retired this cycle, no trap
- csr_addr  input  12  CSR address
- csr_op  input  2  00 none, 01 write, 10 set, 11 clear
- csr_wdata  input  32  rs1 value or zero-extended uimm
- csr_rdata  output  32  combinational old value of the addressed CSR
- csr_illegal  output  1  addressed CSR unimplemented, or write to a read-only CSR
- redirect_valid  output  1  PC must be redirected this cycle
- redirect_pc  output  32  redirect target
- mie_out  output  1  current `mstatus.MIE`

Behaviour:
- Interface: one clock `clk`; `reset` is synchronous and active-high. All state updates on `posedge clk`.
- Reset values:
  - `mstatus.MIE` = 0, `mstatus.MPIE` = 0, `mstatus.MPP` = 2'b11 (hardwired); other `mstatus` bits read 0.
  - `mepc`, `mcause`, `mtval`, `mscratch` = 0; `mtvec` = `{RESET_MTVEC[31:2], 2'b00}`.
  - Reset overrides every other event in the same cycle, including a valid trap or CSR write.
- Outputs are combinational from inputs and current state, zero latency.
  - `redirect_valid` = `trap_pkt.valid && mode != TRAP_NONE`.
  - `TRAP_ENTER`: `redirect_pc` = `mtvec`.
  - `TRAP_RETURN`: `redirect_pc` = current registered `mepc`.
  - Otherwise `redirect_pc` = 0.
  - No handshake: the packet is consumed in the cycle it is valid.
- Trap entry (valid, `TRAP_ENTER`), next edge:
  - `mepc` <= `{trap_pkt.pc[31:2], 2'b00}`.
  - `mcause` <= `{1'b0, zero-extended cause}`.
  - `mtval` <= `trap_pkt.tval`.
  - `MPIE` <= `MIE`; `MIE` <= 0.
- Trap return (valid, `TRAP_RETURN`), next edge:
  - `MIE` <= `MPIE`; `MPIE` <= 1.
  - `mepc`, `mcause`, `mtval` unchanged.
- Back-to-back traps (nested entry): each entry overwrites `mepc`/`mcause`/`mtval`; `MPIE` takes the already-cleared `MIE` (0).
- CSR access:
  - `csr_rdata` always reflects the pre-update value.
  - Write data: write = `wdata`, set = old | `wdata`, clear = old & ~`wdata`.
  - Write masks: `mtvec` [1:0] forced 0 (direct mode only); `mepc` [1:0] forced 0; `mstatus` only bits 3 (MIE) and 7 (MPIE) writable.
  - `mcause` is fully writable.
- Read-only and unimplemented CSRs:
  - `mhartid` returns MHARTID; set/clear with `wdata` = 0 is legal; any write asserts `csr_illegal`.
  - Unimplemented address: `csr_rdata` = 0, `csr_illegal` = 1 whenever `csr_op != 00`.
  - `csr_illegal` suppresses the CSR update.
- Simultaneous events:
  - A valid trap packet suppresses any CSR write in that cycle (the instruction is trapping or is `mret`).
  - `retire` is ignored while `trap_pkt.valid` is high.
- `mie_out` = registered `MIE`.

Optional Feature:
- Macro: `TRAP_CSR_COUNTERS_EN`.
- With the macro defined, 64-bit `mcycle` and `minstret` are implemented:
  - CSRs 0xB00/0xB80 (low), 0xB02/0xB82 (high); reset to 0.
  - `mcycle` increments every non-reset cycle.
  - `minstret` increments when `retire && !trap_pkt.valid`.
  - Low-to-high carry on wrap of the low word 0xFFFF_FFFF.
  - A CSR write to a half replaces that half for that cycle; the increment is dropped for that cycle.
- Without the macro:
  - Those addresses are unimplemented (`rdata` 0, `csr_illegal` on access).
  - No counter flops are synthesized.

Test Plan:
- Reset, then read `mstatus` -> 0x0000_1800; `mtvec` == `RESET_MTVEC` & ~3; `csr_illegal` = 0.
- Write `mtvec` 0x8000_0103, set `MIE`; trap `ENTER` with cause `ILLEGAL_INSTRUCTION` (2), pc 0x0000_0040, tval 0xFFFF_FFFF:
  - same cycle: `redirect_pc` = 0x8000_0100.
  - next cycle: `mepc` = 0x40, `mcause` = 2, `mtval` = 0xFFFF_FFFF, `MIE` = 0, `MPIE` = 1.
- Then trap `RETURN` -> `redirect_pc` = 0x40 same cycle; next cycle `MIE` = 1, `MPIE` = 1.
- CSR clear on `mstatus` with 0x8 in the same cycle as trap `ENTER` -> CSR write dropped, only trap effects visible; `csr_rdata` shows the old value.
- Access 0x7C0 with op=write -> `csr_illegal` = 1, `rdata` 0, no state change. Write 0xF14 -> `csr_illegal` = 1. `csrrs` 0xF14 with `wdata` 0 -> `rdata` = MHARTID, no illegal.
- Counters enabled:
  - preload `mcycle` low 0xFFFF_FFFF -> next cycle low 0, high +1.
  - 5 `retire` pulses with one coincident trap -> `minstret` +4.
  - assert reset mid-count -> all counters 0 on the next cycle.
